// File: rtl/counter_ctrl.sv
// Command sequencer for the up/down counter: takes LOAD/CLEAR/UP n/DOWN n on a
// valid/ready port and drives the counter pins. Optional saturation: COUNTER_CTRL_SAT_EN.
module counter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] cnt_data_in,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             cnt_up_down,
  input  logic [WIDTH-1:0] cnt_data_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [WIDTH-1:0]    data_q;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]    result_q;
  logic                accept;
  logic [STEP_W-1:0]   cmd_count;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_count = cmd_data[STEP_W-1:0];
  assign result    = result_q;

`ifdef COUNTER_CTRL_SAT_EN
  logic sat_q, sat_d;
  logic at_boundary;

  // Boundary is judged on the counter's registered output, so the enable that
  // would step past it is suppressed in the same cycle.
  assign at_boundary = (op_q == OP_UP) ? (&cnt_data_out) : (cnt_data_out == '0);
  assign sat         = done && sat_q;
`else
  assign sat = 1'b0;
`endif

  // NOTE: every output and next-state signal gets a default before the case, so
  // no path leaves a combinational variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    cnt_load    = 1'b0;
    cnt_enable  = 1'b0;
    cnt_up_down = 1'b0;
    cnt_data_in = '0;
`ifdef COUNTER_CTRL_SAT_EN
    sat_d       = sat_q;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
`ifdef COUNTER_CTRL_SAT_EN
        sat_d     = 1'b0;
`endif
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_LOAD || op_e'(cmd_op) == OP_CLEAR) begin
            state_d = S_LOAD;
          end else if (cmd_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_RUN;
            remaining_d = cmd_count;
          end
        end
      end

      S_LOAD: begin
        cnt_load    = 1'b1;
        cnt_data_in = (op_q == OP_CLEAR) ? '0 : data_q;
        state_d     = S_DONE;
      end

      S_RUN: begin
        cnt_up_down = (op_q == OP_UP);
`ifdef COUNTER_CTRL_SAT_EN
        if (at_boundary) begin
          sat_d       = 1'b1;
          remaining_d = '0;
          state_d     = S_DONE;
        end else begin
          cnt_enable  = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == STEP_W'(1)) state_d = S_DONE;
        end
`else
        cnt_enable  = 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == STEP_W'(1)) state_d = S_DONE;
`endif
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      data_q      <= '0;
      remaining_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
      end
      if (state_q == S_DONE) result_q <= cnt_data_out;
    end
  end

`ifdef COUNTER_CTRL_SAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: behavioural counter, reference model and
// result scoreboard. Honors COUNTER_CTRL_SAT_EN for expected values.
module tb_counter_ctrl;

  localparam int WIDTH = 8;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_CLEAR = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] cnt_data_in;
  logic             cnt_load, cnt_enable, cnt_up_down;
  logic [WIDTH-1:0] cnt_data_out;
  logic             busy, done, sat;
  logic [WIDTH-1:0] result;

  counter_ctrl #(.WIDTH(WIDTH), .STEP_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cnt_data_in(cnt_data_in), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_up_down(cnt_up_down), .cnt_data_out(cnt_data_out),
    .busy(busy), .done(done), .result(result), .sat(sat)
  );

  always #5 clk = ~clk;

  // Behavioural counter datapath the controller drives.
  logic [WIDTH-1:0] cnt_q;
  always @(posedge clk or negedge reset) begin
    if (!reset)          cnt_q <= '0;
    else if (cnt_load)   cnt_q <= cnt_data_in;
    else if (cnt_enable) cnt_q <= cnt_up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end
  assign cnt_data_out = cnt_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             sat;
  } exp_t;
  exp_t sb[$];

  // Monitor: interlock rules, pulse counters, scoreboard compare.
  int               en_cnt = 0, ld_cnt = 0, done_cnt = 0, viol = 0;
  logic [WIDTH-1:0] last_ld_data = '0;
  logic             pending = 1'b0;
  exp_t             cur;

  always @(negedge clk) begin
    if (cnt_load && cnt_enable)        viol++;
    if (!cnt_load && cnt_data_in != 0) viol++;
    if (cnt_up_down && (cnt_load || !busy)) viol++;
    if (cmd_ready == busy)             viol++;
    if (cnt_enable) en_cnt++;
    if (cnt_load) begin
      ld_cnt++;
      last_ld_data = cnt_data_in;
    end
    if (pending) begin
      check("sb_result", result, cur.res);
      pending = 1'b0;
    end
    if (done) begin
      done_cnt++;
      check("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        check("sb_sat", sat, cur.sat);
        pending = 1'b1;
      end
    end
  end

  // Reference model of the counter value as seen by the command stream.
  logic [WIDTH-1:0] model_val = '0;
  logic             after_done = 1'b0;

  task automatic model(input logic [1:0] op, input logic [WIDTH-1:0] d, output exp_t e,
                       output int steps, output int lat, output int loads);
    int n;
    n = int'(d);
    e.sat = 1'b0;
    loads = 0;
    steps = 0;
    if (op == OP_LOAD || op == OP_CLEAR) begin
      model_val = (op == OP_LOAD) ? d : '0;
      loads = 1;
      lat = 2;
    end else if (n == 0) begin
      lat = 1;
    end else begin
      int room;
      room = (op == OP_UP) ? 255 - int'(model_val) : int'(model_val);
`ifdef COUNTER_CTRL_SAT_EN
      if (n > room) begin
        steps = room;
        e.sat = 1'b1;
        lat = room + 2;
      end else begin
        steps = n;
        lat = n + 1;
      end
`else
      steps = n;
      lat = n + 1;
      if (room < 0) lat = 0;
`endif
      model_val = (op == OP_UP) ? model_val + WIDTH'(steps) : model_val - WIDTH'(steps);
    end
    e.res = model_val;
  endtask

  // Drive one command, wait for acceptance, optionally poke cmd_valid while busy.
  task automatic accept_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d, output int waits);
    logic was_ready;
    waits = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    forever begin
      was_ready = cmd_ready;
      @(posedge clk);
      if (was_ready || waits > 20) break;
      waits++;
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input bit poke);
    exp_t e;
    int steps, lat, loads, waits, got_lat;
    en_cnt = 0;
    ld_cnt = 0;
    model(op, d, e, steps, lat, loads);
    accept_cmd(op, d, waits);
    check({name, "_accept_wait"}, waits, after_done ? 1 : 0);
    sb.push_back(e);
    got_lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (poke && i == 2) begin
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD;
        cmd_data = 8'h77;
        check({name, "_ready_busy"}, cmd_ready, 1'b0);
      end
      if (done) begin
        got_lat = i;
        break;
      end
    end
    cmd_valid = 1'b0;
    check({name, "_latency"}, got_lat, lat);
    check({name, "_enables"}, en_cnt, steps);
    check({name, "_loads"}, ld_cnt, loads);
    if (loads == 1) check({name, "_load_data"}, last_ld_data, e.res);
    after_done = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, cmd_ready, 1'b1);
    check({name, "_outs"}, {busy, done, cnt_load, cnt_enable, cnt_up_down, sat}, 6'b0);
    check({name, "_result"}, result, 0);
  endtask

  initial begin
    int waits, done_before;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_init");
    reset = 1'b1;
    @(negedge clk);

    run_cmd("load_a5", OP_LOAD, 8'hA5, 1'b0);
    run_cmd("load_10", OP_LOAD, 8'd10, 1'b0);
    run_cmd("up_5", OP_UP, 8'd5, 1'b1);
    run_cmd("load_2", OP_LOAD, 8'd2, 1'b0);
    run_cmd("down_4", OP_DOWN, 8'd4, 1'b0);
    run_cmd("up_0", OP_UP, 8'd0, 1'b0);
    run_cmd("clear", OP_CLEAR, 8'h5A, 1'b0);
    run_cmd("load_fe", OP_LOAD, 8'hFE, 1'b0);
    run_cmd("up_3", OP_UP, 8'd3, 1'b0);
    run_cmd("down_0", OP_DOWN, 8'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [1:0] rop;
      logic [WIDTH-1:0] rd;
      rop = 2'($urandom_range(0, 3));
      rd = (rop == OP_UP || rop == OP_DOWN) ? WIDTH'($urandom_range(0, 40)) : WIDTH'($urandom);
      run_cmd("rand", rop, rd, 1'b0);
    end
    @(negedge clk);

    // Abort an UP 20 after three RUN cycles.
    after_done = 1'b0;
    done_before = done_cnt;
    accept_cmd(OP_UP, 8'd20, waits);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_enable_before", cnt_enable, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt, done_before);
    run_cmd("post_abort_up0", OP_UP, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("interlock_violations", viol, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
